// File: rtl/inst_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : inst_buffer_pkg
// Brief   : Shared decode/rename types and instruction-buffer sizing constants.
// Revision: 1.0 - initial release
// ============================================================================
package inst_buffer_pkg;

    localparam int c_FETCH_WIDTH    = 4;
    localparam int c_DISPATCH_WIDTH = 4;
    localparam int c_DEPTH          = 32;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [31:0] ctrl;
    } renPkt;

    localparam int c_PKT_W = $bits(renPkt);
    localparam int c_PTR_W = $clog2(c_DEPTH);

    typedef logic [c_PTR_W-1:0] ib_ptr_t;
    typedef logic [c_PTR_W:0]   ib_cnt_t;

endpackage
`default_nettype wire

// File: rtl/ib_enq_compact.sv
`default_nettype none
// ============================================================================
// Module  : ib_enq_compact
// Brief   : Prefix-popcount compaction of sparse decode slots onto queue indices.
// Revision: 1.0 - initial release
// ============================================================================
module ib_enq_compact
    import inst_buffer_pkg::*;
#(
    parameter int SLOTS = 2 * c_FETCH_WIDTH,
    parameter int PTR_W = c_PTR_W,
    parameter int SC_W  = $clog2(SLOTS + 1)
) (
    input  logic [SLOTS-1:0]            valid,
    input  logic [PTR_W-1:0]            tail,
    output logic [SLOTS-1:0][PTR_W-1:0] wr_idx,
    output logic [SLOTS-1:0]            wr_en,
    output logic [SC_W-1:0]             n_enq
);

    logic [SC_W-1:0] w_acc;

    // Slot k lands at tail plus the number of valid slots below it.
    always_comb begin
        w_acc  = '0;
        wr_idx = '0;
        for (int k = 0; k < SLOTS; k++) begin
            wr_idx[k] = tail + PTR_W'(w_acc);
            w_acc     = w_acc + SC_W'(valid[k]);
        end
        n_enq = w_acc;
    end

    assign wr_en = valid;

endmodule
`default_nettype wire

// File: rtl/inst_buffer.sv
`default_nettype none
// ============================================================================
// Module  : inst_buffer
// Brief   : Circular decode-to-rename instruction queue with fixed-size bundles.
// Revision: 1.0 - initial release
// ============================================================================
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int FETCH_WIDTH    = c_FETCH_WIDTH,
    parameter int DISPATCH_WIDTH = c_DISPATCH_WIDTH,
    parameter int DEPTH          = c_DEPTH,
    parameter int PKT_W          = c_PKT_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush_i,
    input  logic                              decWrEn_i,
    input  logic [2*FETCH_WIDTH*PKT_W-1:0]    ibPacket_i,
    input  logic [2*FETCH_WIDTH-1:0]          ibValid_i,
    input  logic                              renameReady_i,
    output logic [DISPATCH_WIDTH*PKT_W-1:0]   bundlePacket_o,
    output logic                              bundleValid_o,
    output logic                              ibStall_o,
    output logic [$clog2(DEPTH):0]            ibCount_o
);

    localparam int c_SLOTS = 2 * FETCH_WIDTH;
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SC_W  = $clog2(c_SLOTS + 1);

    localparam logic [c_CNT_W-1:0] c_STALL_TH = c_CNT_W'(DEPTH - c_SLOTS);
    localparam logic [c_CNT_W-1:0] c_DW_CNT   = c_CNT_W'(DISPATCH_WIDTH);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [PKT_W-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic [c_SLOTS-1:0][c_PTR_W-1:0] w_wr_idx;
    logic [c_SLOTS-1:0]              w_wr_en;
    logic [c_SC_W-1:0]               w_n_enq_raw;
    logic [c_CNT_W-1:0]              w_n_enq;
    logic [c_CNT_W-1:0]              w_n_deq;
    logic                            w_enq;
    logic                            w_deq;

    ib_enq_compact #(
        .SLOTS (c_SLOTS),
        .PTR_W (c_PTR_W),
        .SC_W  (c_SC_W)
    ) u_compact (
        .valid  (ibValid_i),
        .tail   (r_tail),
        .wr_idx (w_wr_idx),
        .wr_en  (w_wr_en),
        .n_enq  (w_n_enq_raw)
    );

    // Stall looks only at registered occupancy and ignores same-cycle dequeue.
    assign ibStall_o     = r_count > c_STALL_TH;
    assign bundleValid_o = r_count >= c_DW_CNT;
    assign ibCount_o     = r_count;

    assign w_enq   = decWrEn_i & ~ibStall_o & ~flush_i;
    assign w_deq   = bundleValid_o & renameReady_i & ~flush_i;
    assign w_n_enq = w_enq ? c_CNT_W'(w_n_enq_raw) : '0;
    assign w_n_deq = w_deq ? c_DW_CNT : '0;

    generate
        for (genvar i = 0; i < DISPATCH_WIDTH; i++) begin : g_bundle
            assign bundlePacket_o[i*PKT_W +: PKT_W] = r_mem[r_head + c_PTR_W'(i)];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int k = 0; k < c_SLOTS; k++) begin
            if (w_enq && w_wr_en[k]) begin
                r_mem[w_wr_idx[k]] <= ibPacket_i[k*PKT_W +: PKT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + c_PTR_W'(w_n_enq);
            r_head  <= r_head + c_PTR_W'(w_n_deq);
            r_count <= r_count + w_n_enq - w_n_deq;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (r_count <= c_DEPTH_CNT)
                else $error("inst_buffer occupancy exceeds depth");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_buffer
// Brief   : Self-checking bench for inst_buffer against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int c_FW    = 4;
    localparam int c_DW    = 4;
    localparam int c_DEPTH = 32;
    localparam int c_PW    = $bits(renPkt);
    localparam int c_SL    = 2 * c_FW;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    flush_i;
    logic                    decWrEn_i;
    logic [c_SL*c_PW-1:0]    ibPacket_i;
    logic [c_SL-1:0]         ibValid_i;
    logic                    renameReady_i;
    logic [c_DW*c_PW-1:0]    bundlePacket_o;
    logic                    bundleValid_o;
    logic                    ibStall_o;
    logic [$clog2(c_DEPTH):0] ibCount_o;

    inst_buffer #(
        .FETCH_WIDTH    (c_FW),
        .DISPATCH_WIDTH (c_DW),
        .DEPTH          (c_DEPTH),
        .PKT_W          (c_PW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .decWrEn_i      (decWrEn_i),
        .ibPacket_i     (ibPacket_i),
        .ibValid_i      (ibValid_i),
        .renameReady_i  (renameReady_i),
        .bundlePacket_o (bundlePacket_o),
        .bundleValid_o  (bundleValid_o),
        .ibStall_o      (ibStall_o),
        .ibCount_o      (ibCount_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       flush;
        logic       wr;
        logic [7:0] valid;
        logic       ready;
        int         exp_count;
        logic       exp_bv;
        logic       exp_stall;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          tag_base = 0;
    logic [c_PW-1:0] model_q [$];
    logic [c_PW-1:0] cur_pk [c_SL];
    vec_t        vecs [28];

    function automatic vec_t mk(logic r, logic f, logic w, logic [7:0] v, logic rd,
                                int c, logic bv, logic st);
        vec_t t;
        t.rst = r; t.flush = f; t.wr = w; t.valid = v; t.ready = rd;
        t.exp_count = c; t.exp_bv = bv; t.exp_stall = st;
        return t;
    endfunction

    task automatic check(input string name, input logic [c_PW-1:0] act, input logic [c_PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs come straight from the model queue contents.
    task automatic check_model();
        int sz;
        sz = model_q.size();
        check("count", c_PW'(ibCount_o), c_PW'(sz));
        check("bundleValid", c_PW'(bundleValid_o), c_PW'(sz >= c_DW));
        check("ibStall", c_PW'(ibStall_o), c_PW'((c_DEPTH - sz) < c_SL));
        if (sz >= c_DW) begin
            for (int i = 0; i < c_DW; i++) begin
                check("bundleSlot", bundlePacket_o[i*c_PW +: c_PW], model_q[i]);
            end
        end
    endtask

    task automatic model_update(input logic r, input logic f, input logic w,
                                input logic [7:0] v, input logic rd);
        int   sz;
        logic st;
        logic bv;
        sz = model_q.size();
        st = (c_DEPTH - sz) < c_SL;
        bv = sz >= c_DW;
        if (r || f) begin
            model_q.delete();
        end else begin
            if (bv && rd) begin
                repeat (c_DW) void'(model_q.pop_front());
            end
            if (w && !st) begin
                for (int k = 0; k < c_SL; k++) begin
                    if (v[k]) model_q.push_back(cur_pk[k]);
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic f, input logic w,
                         input logic [7:0] v, input logic rd);
        check_model();
        for (int k = 0; k < c_SL; k++) begin
            cur_pk[k] = {$urandom, $urandom, $urandom, 32'(tag_base + k)};
            ibPacket_i[k*c_PW +: c_PW] = cur_pk[k];
        end
        reset         = r;
        flush_i       = f;
        decWrEn_i     = w;
        ibValid_i     = v;
        renameReady_i = rd;
        @(posedge clk);
        model_update(r, f, w, v, rd);
        tag_base = r ? 0 : tag_base + c_SL;
        #1;
    endtask

    initial begin
        logic [7:0] pats [8];
        logic [7:0] rv;

        reset = 1'b1; flush_i = 1'b0; decWrEn_i = 1'b0;
        ibValid_i = '0; renameReady_i = 1'b0; ibPacket_i = '0;
        repeat (2) @(posedge clk);
        #1;
        model_q.delete();

        //                rst  fl  wr  valid    rdy  cnt bv st
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b1, 8'h55, 1'b0,  4, 1'b1, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0,  8, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 16, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 24, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 25, 1'b1, 1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 25, 1'b1, 1'b1);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 8'h07, 1'b0,  3, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1,  3, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 8'h10, 1'b1,  4, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1,  0, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0,  8, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 16, 1'b1, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 20, 1'b1, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1,  0, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 1'b1, 8'hF0, 1'b0,  4, 1'b1, 1'b0);
        vecs[18] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0,  0, 1'b0, 1'b0);
        vecs[19] = mk(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1,  0, 1'b0, 1'b0);
        vecs[20] = mk(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0,  8, 1'b1, 1'b0);
        vecs[21] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  0, 1'b0, 1'b0);
        vecs[22] = mk(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0,  8, 1'b1, 1'b0);
        vecs[23] = mk(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 16, 1'b1, 1'b0);
        vecs[24] = mk(1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 17, 1'b1, 1'b0);
        vecs[25] = mk(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1,  0, 1'b0, 1'b0);
        vecs[26] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0,  0, 1'b0, 1'b0);
        vecs[27] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1,  0, 1'b0, 1'b0);

        for (int i = 0; i < 28; i++) begin
            cycle(vecs[i].rst, vecs[i].flush, vecs[i].wr, vecs[i].valid, vecs[i].ready);
            check($sformatf("row%0d count", i), c_PW'(ibCount_o), c_PW'(vecs[i].exp_count));
            check($sformatf("row%0d bundleValid", i), c_PW'(bundleValid_o), c_PW'(vecs[i].exp_bv));
            check($sformatf("row%0d ibStall", i), c_PW'(ibStall_o), c_PW'(vecs[i].exp_stall));
            // Payload low word equals slot index on the first post-reset write.
            if (i == 1) begin
                for (int s = 0; s < c_DW; s++) begin
                    check($sformatf("first bundle slot%0d", s),
                          c_PW'(bundlePacket_o[s*c_PW +: 32]), c_PW'(2 * s));
                end
            end
        end

        // Steady state: four in, four out per cycle, pointers wrap repeatedly.
        pats[0] = 8'h0F; pats[1] = 8'h33; pats[2] = 8'h55; pats[3] = 8'hAA;
        pats[4] = 8'hF0; pats[5] = 8'h3C; pats[6] = 8'hC3; pats[7] = 8'h99;
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        for (int c = 0; c < 40; c++) begin
            cycle(1'b0, 1'b0, 1'b1, pats[c % 8], 1'b1);
            check("steady count", c_PW'(ibCount_o), c_PW'(8));
        end

        // Random traffic: arbitrary popcounts make write groups straddle index 31.
        for (int c = 0; c < 400; c++) begin
            rv = 8'($urandom);
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                  1'($urandom), rv, ($urandom_range(0, 2) != 0));
        end
        check_model();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Circular instruction queue directly downstream of the decode stage.
- Accepts up to 2*FETCH_WIDTH decoded packets per cycle; decode emits two slots per fetch lane, and the slots are sparsely valid.
- Compacts valid packets in order into the queue.
- Presents fixed DISPATCH_WIDTH bundles to rename.
- Throttles decode/fetch through a stall output; flushed on recovery.

Parameters:
- FETCH_WIDTH, 4, fetch/decode lanes; enqueue slots = 2*FETCH_WIDTH.
- DISPATCH_WIDTH, 4, packets per bundle sent to rename.
- DEPTH, 32, queue entries; power of two, >= 2*FETCH_WIDTH + DISPATCH_WIDTH.
- PKT_W, 128, bits per renamed-instruction packet, excluding its valid bit.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  recovery/exception flush; empties the queue.
- decWrEn_i  in  1  decode has a packet group this cycle.
- ibPacket_i  in  2*FETCH_WIDTH*PKT_W  packet slots; slot k occupies bits [k*PKT_W +: PKT_W].
- ibValid_i  in  2*FETCH_WIDTH  per-slot valid.
- renameReady_i  in  1  rename accepts a bundle this cycle.
- bundlePacket_o  out  DISPATCH_WIDTH*PKT_W  head..head+DISPATCH_WIDTH-1 entries, oldest in slot 0.
- bundleValid_o  out  1  full bundle available.
- ibStall_o  out  1  free entries < 2*FETCH_WIDTH; upstream must hold.
- ibCount_o  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- State: head and tail pointers (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits), DEPTH x PKT_W storage.
- Reset: head=tail=count=0, so bundleValid_o=0, ibStall_o=0, ibCount_o=0. Storage contents are not reset; bundlePacket_o is don't-care while bundleValid_o=0.
- ibStall_o = (DEPTH - count) < 2*FETCH_WIDTH.
  - Derived only from registered count, so no combinational path from any input.
  - Conservative: ignores any same-cycle dequeue.
- Enqueue: enq = decWrEn_i & ~ibStall_o & ~flush_i.
  - Valid slots are written in ascending slot order to tail, tail+1, ... (mod DEPTH); invalid slots are skipped.
  - Slot k goes to tail + popcount(ibValid_i[k-1:0]).
  - nEnq = popcount(ibValid_i) when enq, else 0.
  - decWrEn_i while ibStall_o is high: no write. Upstream holds its data; no loss is allowed.
- bundleValid_o = (count >= DISPATCH_WIDTH). bundlePacket_o reads combinationally from storage at head+i.
- Dequeue: deq = bundleValid_o & renameReady_i & ~flush_i; nDeq = DISPATCH_WIDTH when deq, else 0. Partial bundles are never sent.
- Update: tail += nEnq; head += nDeq; count += nEnq - nDeq, all in the same cycle.
  - A simultaneous enqueue and dequeue is legal.
  - Overflow is impossible by construction. Assert count <= DEPTH.
- Latency: a packet enqueued in cycle N is visible on bundlePacket_o from cycle N+1, once count >= DISPATCH_WIDTH.
- Flush, which has priority over everything except reset:
  - Next cycle head=tail=count=0.
  - Same-cycle enqueue and dequeue are suppressed.
  - A flush asserted on consecutive cycles keeps the queue empty.
- Reset mid-operation: identical to the reset state next cycle, regardless of in-flight enq/deq/flush.
- Wrap-around: a group of writes may straddle index DEPTH-1 -> 0, and a bundle read may straddle the same boundary. Both use modulo-DEPTH index arithmetic.
- ibValid_i = 0 with decWrEn_i = 1: no-op, no pointer change.

Decomposition:
- Shared package (decode/rename package):
  - renPkt typedef; PKT_W = $bits(renPkt).
  - Queue-depth and width constants.
  - Pointer/count typedefs sized from DEPTH.
- Sub-module ib_enq_compact (combinational):
  - Inputs: ibValid_i and tail.
  - Outputs: per-slot write index, per-slot write enable, nEnq.
  - Implemented as a prefix popcount.
- Storage, pointers and count live in inst_buffer.

Test Plan (FETCH_WIDTH=4, DISPATCH_WIDTH=4, DEPTH=32):
- Reset, then one enq with ibValid_i=8'b01010101, payload = slot index -> ibCount_o=4 next cycle; bundleValid_o=1; bundle slots 0..3 = payloads 0,2,4,6.
- renameReady_i=0; enq 8,8,8 valid, then 1 valid -> counts 8,16,24,25. ibStall_o=0 at count 24 (free 8). ibStall_o=1 at count 25. A further decWrEn_i with 8 valid leaves count 25.
- Count=3 with renameReady_i=1 -> bundleValid_o=0, no dequeue. Enq 1 valid -> next cycle count 4, bundleValid_o=1.
- Steady state at count 8 with 4 valid enq + dequeue every cycle -> count stays 8. Over 40 cycles tail and head wrap past 31. Output sequence matches input order exactly, including bundles straddling index 31 -> 0.
- Count 20 with flush_i=1 together with enq 8 valid and renameReady_i=1 -> next cycle count 0, bundleValid_o=0, ibStall_o=0. Following enq of 4 lands at index 0.
- reset asserted mid-stream at count 17 with simultaneous enq/deq -> next cycle count 0, all outputs at reset values.
